cim_weight_loader: RTL and testbench
====================================

# cim_weight_loader

Write-side sequencer for the dual-bank CIM storage array. It accepts a valid/ready stream of 24-bit weight words and turns each complete load into eight one-hot row-write strobes on the array's write-address ports `WA0`/`WA1`, with data presented on `D`. It sits between the weight DMA/stream source and `cim_array`, and is the only driver of the array's write interface.

## Interface
Parameters:
- `DATA_W`, 24: weight word width; must equal the array `D` width.
- `ROWS`, 8: rows per bank; must equal the `WA0`/`WA1` width, because WA is a one-hot row select.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `bank_sel`  in  2  target banks: bit0 is bank0, bit1 is bank1. Sampled with `start`.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DATA_W  stream word.
- `s_ready`  out  1  stream ready.
- `WA0`  out  ROWS  bank0 one-hot row write strobe; all-zero means no write.
- `WA1`  out  ROWS  bank1 one-hot row write strobe.
- `D`  out  DATA_W  write data to both banks.
- `busy`  out  1  high in LOAD and DONE.
- `done`  out  1  one-cycle pulse marking completion of a load.
- `err`  out  1  one-cycle pulse when an illegal `start` is rejected.

## Operation
- There is no separate write enable. A write happens only in a cycle where `WAx` is non-zero, and `WAx` carries at most one set bit.
- State machine `IDLE`, `LOAD`, `DONE`:
  - **IDLE**
    - If `start=1` and `bank_sel` is legal: latch `bank_sel`, set row counter `row=0`, go to LOAD.
    - If `start=1` and `bank_sel` is illegal: pulse `err` the next cycle and stay in IDLE.
    - `s_ready=0`.
  - **LOAD**
    - `s_ready=1`.
    - Each handshake (`s_valid & s_ready`) is one accepted beat. For each beat:
      - register `D<=s_data`;
      - register `WA0<=(1<<row)` if latched bit0 is set, else 0;
      - register `WA1` the same way from latched bit1;
      - increment `row`.
    - A cycle with no beat registers `WA0=WA1=0`; `D` holds its value.
    - When the beat with `row==ROWS-1` is accepted, go to DONE.
  - **DONE**
    - Lasts one cycle. `done=1`, `s_ready=0`.
    - The last row's strobe is visible in this same cycle.
    - Then go to IDLE, where `WA0/WA1` return to 0.
- `start` in LOAD or DONE is ignored: no error, and `bank_sel` is not resampled.
- Legal `bank_sel` values:
  - `2'b01` and `2'b10` are always legal.
  - `2'b00` is always illegal.
  - `2'b11` depends on configuration (see below).
- Rows are written in ascending order, 0 to ROWS-1. There is no wrap-around; the row counter resets to 0 on every load.
- The stream is never overrun. If `s_valid` stays high in DONE or IDLE, words are not consumed.

## Timing
- Reset (asynchronous, immediate): state is IDLE and `row=0`. All outputs are 0: `WA0`, `WA1`, `D`, `s_ready`, `busy`, `done`, `err`.
- Reset mid-load: strobes drop immediately. Rows already written stay in the array and no `done` is produced.
- Latency:
  - A beat accepted at cycle t drives its strobe and data at t+1 for exactly one cycle.
  - `start` at cycle t gives `s_ready=1` and `busy=1` at t+1.
- Minimum load time with `s_valid` held high is ROWS+1 cycles from the first LOAD cycle to DONE. A new `start` is accepted no earlier than the cycle after DONE.
- Back-to-back beats produce strobes on consecutive cycles with shifting one-hot positions. Stall cycles insert all-zero WA cycles.
- All outputs are registered, except `s_ready`, which is decoded from the state register.

## Configuration
- Macro: `CIM_LOADER_BROADCAST_EN`.
- Defined: `bank_sel=2'b11` is legal. Each beat drives identical one-hot strobes on `WA0` and `WA1` in the same cycle, writing the same row of both banks.
- Undefined: `bank_sel=2'b11` is illegal. It behaves exactly like `2'b00` (err pulse, stay IDLE), and `WA0`/`WA1` are never non-zero in the same cycle.

## Test plan
- Reset, then `start`, `bank_sel=01`, with 8 back-to-back words 0x000001 to 0x000008:
  - `WA0` = 0x01, 0x02, ..., 0x80 on 8 consecutive cycles, with `D` matching each word;
  - `WA1` stays 0;
  - `done` pulses with the 0x80 strobe, then `busy=0`.
- Same load to bank1 with `s_valid` deasserted for 2 cycles after word 3:
  - `WA1` is 0x00 during the gap;
  - ordering is preserved and `done` is delayed by 2 cycles.
- `start` with `bank_sel=00`:
  - `err` pulses one cycle later;
  - `s_ready`, `busy` and WA stay 0.
- `start` with `bank_sel=11`:
  - with `CIM_LOADER_BROADCAST_EN`, `WA0==WA1` for each of the 8 strobes;
  - without it, `err` pulses and no strobes occur.
- Assert `rst_n=0` after 4 beats:
  - all outputs are 0 in the same cycle;
  - after release, a fresh load starts again at row 0 (`WA`=0x01).
- `start` pulsed during LOAD:
  - it is ignored and no `err` pulse occurs;
  - the load completes with the original `bank_sel`.

Source files
------------

// File: rtl/cim_weight_loader.sv
// Write-side sequencer for the dual-bank CIM array: turns a stream of weight words into
// one-hot row-write strobes on WA0/WA1. Optional feature macro: CIM_LOADER_BROADCAST_EN.
module cim_weight_loader #(
  parameter int DATA_W = 24,
  parameter int ROWS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        bank_sel,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ROWS-1:0]   WA0,
  output logic [ROWS-1:0]   WA1,
  output logic [DATA_W-1:0] D,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    row, row_nxt;
  logic [1:0]          sel_q, sel_nxt;
  logic                beat;
  logic                err_nxt;
  logic [ROWS-1:0]     row_hot;
  logic [ROWS-1:0]     wa0_p1, wa1_p1;
  logic [DATA_W-1:0]   d_p1;

  // Broadcast to both banks is only a legal target when the feature is built in.
  function automatic logic sel_is_legal(input logic [1:0] sel);
`ifdef CIM_LOADER_BROADCAST_EN
    return (sel != 2'b00);
`else
    return (sel == 2'b01) || (sel == 2'b10);
`endif
  endfunction

  assign s_ready = (state == LOAD);
  assign row_hot = ROWS'(1) << row;

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    sel_nxt   = sel_q;
    err_nxt   = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (sel_is_legal(bank_sel)) begin
            sel_nxt   = bank_sel;
            row_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          beat    = 1'b1;
          row_nxt = row + 1'b1;
          if (row == ROW_W'(ROWS - 1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 0: control state, row counter and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      sel_q <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      sel_q <= sel_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      err   <= err_nxt;
    end
  end

  // Stage 1: registered strobes and write data, one cycle after the accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa0_p1 <= '0;
      wa1_p1 <= '0;
      d_p1   <= '0;
    end else begin
      wa0_p1 <= (beat && sel_q[0]) ? row_hot : '0;
      wa1_p1 <= (beat && sel_q[1]) ? row_hot : '0;
      if (beat) d_p1 <= s_data;
    end
  end

  assign WA0 = wa0_p1;
  assign WA1 = wa1_p1;
  assign D   = d_p1;

endmodule

// File: tb/tb_cim_weight_loader.sv
// Directed, scoreboard-checked bench for cim_weight_loader (follows CIM_LOADER_BROADCAST_EN if defined).
module tb_cim_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  bank_sel;
  logic        s_valid;
  logic [23:0] s_data;
  logic        s_ready;
  logic [7:0]  WA0, WA1;
  logic [23:0] D;
  logic        busy, done, err;

  typedef struct {
    logic [7:0]  wa0;
    logic [7:0]  wa1;
    logic [23:0] d;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   failed = 0;

  cim_weight_loader #(.DATA_W(24), .ROWS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .WA0(WA0), .WA1(WA1), .D(D), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every non-zero strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && (WA0 != 8'h00 || WA1 != 8'h00)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {WA1, WA0}, 16'h0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_wa0", WA0, e.wa0);
        chk("sb_wa1", WA1, e.wa1);
        chk("sb_d", D, e.d);
        chk("sb_done", done, e.done);
      end
    end
  end

  task automatic push_exp(input logic [1:0] sel, input int i, input logic [23:0] data);
    exp_t e;
    logic [7:0] hot;
    hot    = 8'h01 << i;
    e.wa0  = sel[0] ? hot : 8'h00;
    e.wa1  = sel[1] ? hot : 8'h00;
    e.d    = data;
    e.done = (i == 7);
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [23:0] base,
                         input int gap_after, input int gap_len, input int glitch_at);
    int ncyc;
    int exp_cyc;
    start = 1'b1;
    bank_sel = sel;
    step();
    start = 1'b0;
    bank_sel = 2'b00;
    chk("ld_s_ready", s_ready, 1);
    chk("ld_busy", busy, 1);
    ncyc = 0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = base + 24'(i);
      push_exp(sel, i, base + 24'(i));
      if (i == glitch_at) begin
        start = 1'b1;
        bank_sel = ~sel;
      end
      step();
      ncyc++;
      start = 1'b0;
      bank_sel = 2'b00;
      if (i == glitch_at) chk("glitch_no_err", err, 0);
      if (i == gap_after - 1) begin
        s_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          step();
          ncyc++;
          chk("gap_wa0", WA0, 0);
          chk("gap_wa1", WA1, 0);
          chk("gap_done", done, 0);
        end
      end
    end
    s_valid = 1'b0;
    exp_cyc = (gap_after > 0) ? 8 + gap_len : 8;
    chk("ld_done", done, 1);
    chk("ld_cycles", ncyc, exp_cyc);
    chk("done_s_ready", s_ready, 0);
    chk("done_busy", busy, 1);
    step();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_wa0", WA0, 0);
    chk("post_wa1", WA1, 0);
    chk("post_d_hold", D, base + 24'd7);
  endtask

  task automatic illegal_start(input logic [1:0] sel);
    start = 1'b1;
    bank_sel = sel;
    step();
    start = 1'b0;
    bank_sel = 2'b00;
    chk("ill_err", err, 1);
    chk("ill_s_ready", s_ready, 0);
    chk("ill_busy", busy, 0);
    chk("ill_wa", {WA1, WA0}, 0);
    step();
    chk("ill_err_pulse", err, 0);
    chk("ill_s_ready2", s_ready, 0);
    chk("ill_busy2", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bank_sel = 2'b00;
    s_valid = 1'b0;
    s_data = 24'h0;
    step();
    chk("rst_wa0", WA0, 0);
    chk("rst_wa1", WA1, 0);
    chk("rst_d", D, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // s_valid high while idle must not consume anything
    s_valid = 1'b1;
    s_data = 24'hABCDEF;
    step();
    chk("idle_no_ready", s_ready, 0);
    s_valid = 1'b0;

    do_load(2'b01, 24'h000001, 0, 0, -1);
    do_load(2'b10, 24'h000001, 3, 2, -1);
    illegal_start(2'b00);
`ifdef CIM_LOADER_BROADCAST_EN
    do_load(2'b11, 24'h000100, 0, 0, -1);
`else
    illegal_start(2'b11);
`endif
    do_load(2'b01, 24'h000200, 0, 0, 3);

    // Reset in the middle of a load, after four beats
    start = 1'b1;
    bank_sel = 2'b01;
    step();
    start = 1'b0;
    bank_sel = 2'b00;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = 24'h000300 + 24'(i);
      push_exp(2'b01, i, 24'h000300 + 24'(i));
      step();
    end
    s_valid = 1'b0;
    begin
      exp_t e;
      e = exp_q.pop_back();
      chk("pre_rst_wa0", WA0, e.wa0);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wa0", WA0, 0);
    chk("mid_rst_wa1", WA1, 0);
    chk("mid_rst_d", D, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    do_load(2'b01, 24'h000400, 0, 0, -1);

    step();
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
